// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL / downstream reset consumers.
// The master side is the supervisor; the slave side is the PLL and system logic.
interface pll_lock_supervisor_if;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       fault;
   logic [7:0] lock_lost_count;
   logic [2:0] state;

   modport master (
      input  pll_locked,
      output pll_rst,
      output sys_rst,
      output fault,
      output lock_lost_count,
      output state
   );

   modport slave (
      output pll_locked,
      input  pll_rst,
      input  sys_rst,
      input  fault,
      input  lock_lost_count,
      input  state
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset and holds the system in reset until PLL lock has been stable,
// with bounded lock retries, a sticky fault and a saturating lock-loss counter.
module pll_lock_supervisor #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master pll_bus
);

   localparam int unsigned RW = $clog2(PLL_RST_CYCLES + 1);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned NW = $clog2(MAX_RETRIES + 1);

   localparam logic [RW-1:0] RST_LAST   = RW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] STB_LAST   = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [NW-1:0] RETRY_LAST = NW'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   logic          r_sync1;
   logic          r_locked_s;
   state_t        r_state;
   logic [RW-1:0] r_rst_cnt;
   logic [TW-1:0] r_to_cnt;
   logic [SW-1:0] r_stb_cnt;
   logic [NW-1:0] r_retry;
   logic [7:0]    r_lost_cnt;
   logic          r_pll_rst;
   logic          r_sys_rst;
   logic          r_fault;

   state_t        w_state_nxt;
   logic [RW-1:0] w_rst_cnt_nxt;
   logic [TW-1:0] w_to_cnt_nxt;
   logic [SW-1:0] w_stb_cnt_nxt;
   logic [NW-1:0] w_retry_nxt;
   logic [7:0]    w_lost_cnt_nxt;
   logic          w_pll_rst_nxt;
   logic          w_sys_rst_nxt;
   logic          w_fault_nxt;

   // pll_locked is asynchronous to refclk; only r_locked_s is used beyond this point.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_sync1    <= pll_bus.pll_locked;
         r_locked_s <= r_sync1;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state    <= ST_PLL_RST;
         r_rst_cnt  <= '0;
         r_to_cnt   <= '0;
         r_stb_cnt  <= '0;
         r_retry    <= '0;
         r_lost_cnt <= '0;
         r_pll_rst  <= 1'b1;
         r_sys_rst  <= 1'b1;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rst_cnt  <= w_rst_cnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
         r_stb_cnt  <= w_stb_cnt_nxt;
         r_retry    <= w_retry_nxt;
         r_lost_cnt <= w_lost_cnt_nxt;
         r_pll_rst  <= w_pll_rst_nxt;
         r_sys_rst  <= w_sys_rst_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rst_cnt_nxt  = r_rst_cnt;
      w_to_cnt_nxt   = r_to_cnt;
      w_stb_cnt_nxt  = r_stb_cnt;
      w_retry_nxt    = r_retry;
      w_lost_cnt_nxt = r_lost_cnt;
      case (r_state)
         ST_PLL_RST: begin
            if (r_rst_cnt == RST_LAST) begin
               w_state_nxt  = ST_WAIT_LOCK;
               w_to_cnt_nxt = '0;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            if (r_locked_s) begin
               w_state_nxt   = ST_STABLE;
               w_stb_cnt_nxt = SW'(1);
            end else if (r_to_cnt == TO_LAST) begin
               w_retry_nxt = r_retry + 1'b1;
               if (r_retry == RETRY_LAST) begin
                  w_state_nxt = ST_FAULT;
               end else begin
                  w_state_nxt   = ST_PLL_RST;
                  w_rst_cnt_nxt = '0;
               end
            end else begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         ST_STABLE: begin
            // A lock drop wins over a completing stable window.
            if (!r_locked_s) begin
               w_state_nxt  = ST_WAIT_LOCK;
               w_to_cnt_nxt = '0;
            end else if (r_stb_cnt >= STB_LAST) begin
               w_state_nxt = ST_RUN;
               w_retry_nxt = '0;
            end else begin
               w_stb_cnt_nxt = r_stb_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (!r_locked_s) begin
               w_state_nxt   = ST_PLL_RST;
               w_rst_cnt_nxt = '0;
               if (r_lost_cnt != 8'hFF) begin
                  w_lost_cnt_nxt = r_lost_cnt + 8'd1;
               end
            end
         end
         ST_FAULT: begin
            w_state_nxt = ST_FAULT;
         end
         default: begin
            w_state_nxt   = ST_PLL_RST;
            w_rst_cnt_nxt = '0;
         end
      endcase
   end

   // Outputs decode the next state so the registered outputs switch on the same edge as state.
   always_comb begin
      w_pll_rst_nxt = 1'b0;
      w_sys_rst_nxt = 1'b1;
      w_fault_nxt   = 1'b0;
      case (w_state_nxt)
         ST_PLL_RST: w_pll_rst_nxt = 1'b1;
         ST_RUN:     w_sys_rst_nxt = 1'b0;
         ST_FAULT: begin
            w_pll_rst_nxt = 1'b1;
            w_fault_nxt   = 1'b1;
         end
         default: begin
            w_pll_rst_nxt = 1'b0;
            w_sys_rst_nxt = 1'b1;
         end
      endcase
   end

   assign pll_bus.pll_rst         = r_pll_rst;
   assign pll_bus.sys_rst         = r_sys_rst;
   assign pll_bus.fault           = r_fault;
   assign pll_bus.lock_lost_count = r_lost_cnt;
   assign pll_bus.state           = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters (4/20/8/2); expected
// values are per-edge constants derived by hand from the edge timeline.
module tb_pll_lock_supervisor;

   logic refclk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pll_lock_supervisor_if bus ();

   pll_lock_supervisor #(
      .PLL_RST_CYCLES     (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .pll_bus(bus)
   );

   always #5 refclk = ~refclk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      step(2);
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
      checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst got %b want 1", bus.pll_rst); end
      checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL rst_sys_rst got %b want 1", bus.sys_rst); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", bus.fault); end
      checks++; if (bus.lock_lost_count !== 8'd0) begin errors++; $display("FAIL rst_llc got %0d want 0", bus.lock_lost_count); end
   endtask

   // Test 1: locked tied high, WAIT_LOCK at R4, STABLE at R5, RUN at R12.
   task automatic test_power_up;
      logic [2:0] exp_st;
      logic       exp_pr, exp_sr;
      bus.pll_locked = 1'b1;
      rst = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step(1);
         exp_st = (e < 4) ? 3'd0 : (e == 4) ? 3'd1 : (e < 12) ? 3'd2 : 3'd3;
         exp_pr = (e < 4);
         exp_sr = (e < 12);
         checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL pu_state R%0d got %0d want %0d", e, bus.state, exp_st); end
         checks++; if (bus.pll_rst !== exp_pr) begin errors++; $display("FAIL pu_pll_rst R%0d got %b want %b", e, bus.pll_rst, exp_pr); end
         checks++; if (bus.sys_rst !== exp_sr) begin errors++; $display("FAIL pu_sys_rst R%0d got %b want %b", e, bus.sys_rst, exp_sr); end
      end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL pu_fault got %b want 0", bus.fault); end
      checks++; if (bus.lock_lost_count !== 8'd0) begin errors++; $display("FAIL pu_llc got %0d want 0", bus.lock_lost_count); end
   endtask

   // Test 2: locked low for F0..F9, relock sampled at F10, RUN again at F19.
   task automatic test_lock_loss;
      logic [2:0] exp_st;
      logic       exp_pr, exp_sr;
      logic [7:0] exp_llc;
      bus.pll_locked = 1'b0;
      for (int f = 0; f <= 19; f++) begin
         step(1);
         if (f == 9) bus.pll_locked = 1'b1;
         exp_st  = (f <= 1) ? 3'd3 : (f <= 5) ? 3'd0 : (f <= 11) ? 3'd1 : (f <= 18) ? 3'd2 : 3'd3;
         exp_pr  = (f >= 2 && f <= 5);
         exp_sr  = (f >= 2 && f <= 18);
         exp_llc = (f <= 1) ? 8'd0 : 8'd1;
         checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL ll_state F%0d got %0d want %0d", f, bus.state, exp_st); end
         checks++; if (bus.pll_rst !== exp_pr) begin errors++; $display("FAIL ll_pll_rst F%0d got %b want %b", f, bus.pll_rst, exp_pr); end
         checks++; if (bus.sys_rst !== exp_sr) begin errors++; $display("FAIL ll_sys_rst F%0d got %b want %b", f, bus.sys_rst, exp_sr); end
         checks++; if (bus.lock_lost_count !== exp_llc) begin errors++; $display("FAIL ll_llc F%0d got %0d want %0d", f, bus.lock_lost_count, exp_llc); end
      end
   endtask

   task automatic test_midrun_reset(input string tag);
      rst = 1'b1;
      step(1);
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL %s_state got %0d want 0", tag, bus.state); end
      checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL %s_pll_rst got %b want 1", tag, bus.pll_rst); end
      checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL %s_sys_rst got %b want 1", tag, bus.sys_rst); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL %s_fault got %b want 0", tag, bus.fault); end
      checks++; if (bus.lock_lost_count !== 8'd0) begin errors++; $display("FAIL %s_llc got %0d want 0", tag, bus.lock_lost_count); end
      rst = 1'b0;
   endtask

   // Test 3: glitch seen by the FSM at R10 (stable count 5); full window restarts at R11.
   task automatic test_stable_glitch;
      logic [2:0] exp_st;
      logic       exp_pr, exp_sr;
      bus.pll_locked = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         step(1);
         if (e == 7) bus.pll_locked = 1'b0;
         if (e == 8) bus.pll_locked = 1'b1;
         exp_st = (e <= 3) ? 3'd0 : (e == 4) ? 3'd1 : (e <= 9) ? 3'd2 :
                  (e == 10) ? 3'd1 : (e <= 17) ? 3'd2 : 3'd3;
         exp_pr = (e <= 3);
         exp_sr = (e < 18);
         checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL sg_state R%0d got %0d want %0d", e, bus.state, exp_st); end
         checks++; if (bus.pll_rst !== exp_pr) begin errors++; $display("FAIL sg_pll_rst R%0d got %b want %b", e, bus.pll_rst, exp_pr); end
         checks++; if (bus.sys_rst !== exp_sr) begin errors++; $display("FAIL sg_sys_rst R%0d got %b want %b", e, bus.sys_rst, exp_sr); end
      end
      checks++; if (bus.lock_lost_count !== 8'd0) begin errors++; $display("FAIL sg_llc got %0d want 0", bus.lock_lost_count); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL sg_fault got %b want 0", bus.fault); end
   endtask

   // Test 4: timeouts at R24 and R48, FAULT from R48 and sticky afterwards.
   task automatic test_timeout_fault;
      logic [2:0] exp_st;
      logic       exp_pr, exp_flt;
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      step(1);
      rst = 1'b0;
      for (int e = 1; e <= 48; e++) begin
         step(1);
         exp_st = (e <= 3) ? 3'd0 : (e <= 23) ? 3'd1 : (e <= 27) ? 3'd0 : (e <= 47) ? 3'd1 : 3'd4;
         exp_pr = (e <= 3) || (e >= 24 && e <= 27) || (e == 48);
         exp_flt = (e == 48);
         checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL to_state R%0d got %0d want %0d", e, bus.state, exp_st); end
         checks++; if (bus.pll_rst !== exp_pr) begin errors++; $display("FAIL to_pll_rst R%0d got %b want %b", e, bus.pll_rst, exp_pr); end
         checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL to_sys_rst R%0d got %b want 1", e, bus.sys_rst); end
         checks++; if (bus.fault !== exp_flt) begin errors++; $display("FAIL to_fault R%0d got %b want %b", e, bus.fault, exp_flt); end
      end
      bus.pll_locked = 1'b1;
      for (int c = 0; c < 100; c++) begin
         step(1);
         checks++;
         if (bus.state !== 3'd4 || bus.fault !== 1'b1 || bus.pll_rst !== 1'b1 || bus.sys_rst !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky c%0d got st=%0d flt=%b pr=%b sr=%b want st=4 flt=1 pr=1 sr=1",
                     c, bus.state, bus.fault, bus.pll_rst, bus.sys_rst);
         end
      end
   endtask

   // One timeout, then RUN at R38 must clear the retry count: the next timeout (R65) retries.
   task automatic test_retry_clear;
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      step(1);
      rst = 1'b0;
      for (int e = 1; e <= 89; e++) begin
         step(1);
         if (e == 28) bus.pll_locked = 1'b1;
         if (e == 38) bus.pll_locked = 1'b0;
         if (e == 24) begin checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rc_retry1 R24 got %0d want 0", bus.state); end end
         if (e == 37) begin checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL rc_stable R37 got %0d want 2", bus.state); end end
         if (e == 38) begin checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL rc_run R38 got %0d want 3", bus.state); end end
         if (e == 41) begin checks++; if (bus.lock_lost_count !== 8'd1) begin errors++; $display("FAIL rc_llc R41 got %0d want 1", bus.lock_lost_count); end end
         if (e == 45) begin checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL rc_wait R45 got %0d want 1", bus.state); end end
         if (e == 65) begin checks++; if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL rc_cleared R65 got st=%0d flt=%b want st=0 flt=0", bus.state, bus.fault); end end
         if (e == 89) begin checks++; if (bus.state !== 3'd4 || bus.fault !== 1'b1) begin errors++; $display("FAIL rc_fault R89 got st=%0d flt=%b want st=4 flt=1", bus.state, bus.fault); end end
      end
   endtask

   // Test 5: 256 one-cycle lock drops in RUN; counter saturates at 255.
   task automatic test_saturation;
      int         n;
      logic [7:0] exp_llc;
      rst = 1'b1;
      bus.pll_locked = 1'b1;
      step(1);
      rst = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         n = 0;
         while (bus.state !== 3'd3 && n < 40) begin step(1); n++; end
         if (bus.state !== 3'd3) begin
            checks++; errors++;
            $display("FAIL sat_wait_run loss%0d got %0d want 3", i, bus.state);
            break;
         end
         bus.pll_locked = 1'b0;
         step(1);
         bus.pll_locked = 1'b1;
         n = 0;
         while (bus.state !== 3'd0 && n < 10) begin step(1); n++; end
         exp_llc = (i > 255) ? 8'd255 : 8'(i);
         checks++;
         if (bus.state !== 3'd0 || bus.lock_lost_count !== exp_llc) begin
            errors++;
            $display("FAIL sat_llc loss%0d got st=%0d llc=%0d want st=0 llc=%0d", i, bus.state, bus.lock_lost_count, exp_llc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_lock_loss();
      test_midrun_reset("rst_in_run");
      test_stable_glitch();
      test_timeout_fault();
      test_midrun_reset("rst_in_fault");
      test_retry_clear();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Consumer-side companion to the SDRAM/system PLL. It runs on the PLL reference clock and drives the PLL's reset input. It watches the PLL `locked` output and releases the system reset to the Nios II and SDRAM controller only after lock has been continuously stable. On loss of lock or lock timeout it re-asserts system reset and re-resets the PLL, with bounded retries and a sticky fault.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse.
- `LOCK_TIMEOUT_CYCLES`, 50000: max cycles in WAIT_LOCK (1 ms @ 50 MHz) before a retry.
- `LOCK_STABLE_CYCLES`, 1000: consecutive synchronized-locked cycles required before releasing `sys_rst`.
- `MAX_RETRIES`, 3: consecutive lock timeouts that cause FAULT.

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst` out 1: active-high system reset to downstream logic.
- `fault` out 1: sticky; PLL failed to lock `MAX_RETRIES` times in a row.
- `lock_lost_count` out 8: count of lock losses in RUN, saturating at 255.
- `state` out 3: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `locked_s` is the second flop. No other logic uses `pll_locked` directly.
- All outputs are registered and change on the same edge as `state`.
- Counter widths are `$clog2(param+1)`. Counters load on state entry.
- **PLL_RST**: `pll_rst`=1, `sys_rst`=1. Exits to WAIT_LOCK after `PLL_RST_CYCLES` cycles.
- **WAIT_LOCK**: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1 → STABLE, with the stable count set to 1.
  - Timeout counter reaching `LOCK_TIMEOUT_CYCLES` → retry+1. Go to FAULT if retry reaches `MAX_RETRIES`, otherwise go to PLL_RST.
- **STABLE**: `sys_rst`=1.
  - `locked_s`=0 → WAIT_LOCK. Timeout restarts, no PLL reset, retry count unchanged.
  - Stable count reaching `LOCK_STABLE_CYCLES` → RUN, retry cleared.
- **RUN**: `sys_rst`=0, `pll_rst`=0. `locked_s`=0 → PLL_RST, `lock_lost_count`+1 (saturating at 255).
- **FAULT**: `pll_rst`=1, `sys_rst`=1, `fault`=1. Terminal; exited only by `rst`.
- Reset values: `state`=PLL_RST, `pll_rst`=1, `sys_rst`=1, `fault`=0, `lock_lost_count`=0, retry=0, synchronizer flops=0.
- `rst` mid-operation, in any state including FAULT: all of the above take their reset values on that edge.
- `rst` dominates every other condition in the same cycle.

## Timing
- Edge numbering: R1 is the first edge with `rst`=0. `pll_rst` stays 1 through edge R`PLL_RST_CYCLES` and is 0 after it.
- Lock acquisition: E0 is the first edge that samples `pll_locked`=1 while in WAIT_LOCK, with `pll_locked` held high.
  - `locked_s`=1 after E1; STABLE is entered at E2.
  - `sys_rst` falls at E0+`LOCK_STABLE_CYCLES`+1.
- Lock loss: F0 is the first edge that samples `pll_locked`=0 in RUN.
  - `sys_rst`, `pll_rst` and the counter increment all take effect at F0+2.
- Pulses on `pll_locked` shorter than one `refclk` period may be missed; this is accepted.
- A drop of `locked_s` in the same cycle the stable count would complete has priority: the block goes to WAIT_LOCK, not RUN.

## Test plan
Parameters for all tests: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
1. Release `rst` with `pll_locked` tied 1 → `pll_rst` falls after R4; `state` passes 1 then 2; `sys_rst` falls at R12 (WAIT_LOCK at R4, STABLE at R5); `fault`=0, `lock_lost_count`=0.
2. In RUN, drive `pll_locked` 0 at F0 for 10 cycles, then 1 → `sys_rst`=1 and `pll_rst`=1 at F0+2; `lock_lost_count`=1; `pll_rst` high for 4 cycles; `sys_rst` falls again 9 cycles after the edge first sampling relock.
3. During STABLE, drop `pll_locked` for 1 cycle at stable count 5 → returns to WAIT_LOCK; `pll_rst` stays 0; full 8-cycle stable window required again; no counter change.
4. `pll_locked` held 0 → two 20-cycle timeouts separated by 4-cycle `pll_rst` pulses; then `state`=4, `fault`=1, `pll_rst`=1, `sys_rst`=1; remains so for 100 cycles even if `pll_locked` goes 1.
5. Force 256 lock losses → `lock_lost_count` saturates at 255.
6. Assert `rst` for 1 cycle while in RUN and while in FAULT → next edge `state`=0, `pll_rst`=1, `sys_rst`=1, `fault`=0, `lock_lost_count`=0.
